// File: rtl/rvv_issue_queue_if.sv
// Handshake bundle between the scalar core, the issue queue and the vector decoder.
// The master side offers instructions and consumes the head; the slave side is the queue.
interface rvv_issue_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;

  modport master (
    output in_valid, in_instr, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, in_instr, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/rvv_issue_queue.sv
// In-order issue FIFO in front of the vector decoder. Owns the architectural vl/vill state and
// resolves vsetvli/vsetivli/vsetvl when they leave the queue.
module rvv_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  rvv_issue_queue_if.slave         iq,
  output logic [31:0]              vl,
  output logic                     vill,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] rs1_q   [DEPTH];
  logic [31:0] rs2_q   [DEPTH];

  ptr_t            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     vl_q, vl_d;
  logic            vill_q, vill_d;
  logic            push, pop;

  logic [31:0] head_instr, head_rs1, head_rs2;

  assign head_instr = instr_q[rptr_q];
  assign head_rs1   = rs1_q[rptr_q];
  assign head_rs2   = rs2_q[rptr_q];

  // Outputs depend on registered state only.
  assign iq.in_ready  = (cnt_q < CntW'(DEPTH));
  assign iq.out_valid = (cnt_q != '0);
  assign iq.out_instr = iq.out_valid ? head_instr : 32'h0;

  assign push  = iq.in_valid && iq.in_ready;
  assign pop   = iq.out_valid && iq.out_ready;
  assign vl    = vl_q;
  assign vill  = vill_q;
  assign count = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_q[wptr_q] <= iq.in_instr;
      rs1_q[wptr_q]   <= iq.in_rs1;
      rs2_q[wptr_q]   <= iq.in_rs2;
    end
  end

  // vset* decode of the head entry
  logic       is_vec_op, is_vsetvli, is_vsetivli, is_vsetvl, is_vset;
  logic [7:0] vtype;
  logic [2:0] vsew, vlmul;
  logic [4:0] rs1_field, rd_field;
  logic [31:0] vlmax_base, vlmax, avl, vl_new;
  logic        illegal, keep_vl;
  logic        unused_vtype;

  assign is_vec_op   = (head_instr[6:0] == 7'b1010111);
  assign is_vsetvli  = is_vec_op && (head_instr[14:12] == 3'b111) && !head_instr[31];
  assign is_vsetivli = is_vec_op && (head_instr[14:12] == 3'b111) &&
                       (head_instr[31:30] == 2'b11);
  assign is_vsetvl   = is_vec_op && (head_instr[14:12] == 3'b110) &&
                       (head_instr[31:25] == 7'b1000000);
  assign is_vset     = is_vsetvli || is_vsetivli || is_vsetvl;

  assign vtype        = is_vsetvl ? head_rs2[7:0] : head_instr[27:20];
  assign vsew         = vtype[5:3];
  assign vlmul        = vtype[2:0];
  assign unused_vtype = ^vtype[7:6];
  assign rs1_field    = head_instr[19:15];
  assign rd_field     = head_instr[11:7];

  assign vlmax_base = 32'(VLEN) >> ({1'b0, vsew} + 4'd3);

  // Fractional LMUL: shift right by 8 - vlmul, i.e. the 3-bit negation of vlmul.
  always_comb begin
    if (!vlmul[2]) vlmax = vlmax_base << vlmul[1:0];
    else           vlmax = vlmax_base >> (3'd0 - vlmul);
  end

  assign illegal = (vsew > 3'd3) || (vlmul == 3'b100) ||
                   (is_vsetvl && (head_rs2[31:8] != 24'h0)) || (vlmax == 32'h0);

  always_comb begin
    if (is_vsetivli)              avl = {27'h0, rs1_field};
    else if (rs1_field != 5'd0)   avl = head_rs1;
    else                          avl = 32'hFFFF_FFFF;
  end

  assign keep_vl = !is_vsetivli && (rs1_field == 5'd0) && (rd_field == 5'd0);
  assign vl_new  = (avl < vlmax) ? avl : vlmax;

  always_comb begin
    vl_d   = vl_q;
    vill_d = vill_q;
    if (pop && !flush && is_vset) begin
      if (illegal) begin
        vl_d   = 32'h0;
        vill_d = 1'b1;
      end else begin
        vill_d = 1'b0;
        if (!keep_vl) vl_d = vl_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vl_q   <= 32'h0;
      vill_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      vl_q   <= vl_d;
      vill_q <= vill_d;
    end
  end

endmodule

// File: tb/tb_rvv_issue_queue.sv
// Directed bench for rvv_issue_queue: scoreboard of issued words plus an occupancy and vl model.
module tb_rvv_issue_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] vl;
  logic        vill;
  logic [2:0]  count;

  rvv_issue_queue_if iq ();

  rvv_issue_queue #(.DEPTH(4), .VLEN(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .iq    (iq.slave),
    .vl    (vl),
    .vill  (vill),
    .count (count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  logic [31:0] vl_exp = 32'h0;
  logic        vill_exp = 1'b0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_vsetvli(input logic [7:0] vt, input logic [4:0] rs1f,
                                            input logic [4:0] rd);
    return {1'b0, 3'b000, vt, rs1f, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] f_vsetivli(input logic [7:0] vt, input logic [4:0] uimm);
    return {2'b11, 2'b00, vt, uimm, 3'b111, 5'd2, 7'h57};
  endfunction

  function automatic logic [31:0] f_vsetvl(input logic [4:0] rs1f);
    return {7'b1000000, 5'd6, rs1f, 3'b110, 5'd1, 7'h57};
  endfunction

  // One cycle: drive at the falling edge, check before and after the rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic ordy);
    @(negedge clk);
    iq.in_valid  = v;
    iq.in_instr  = ins;
    iq.in_rs1    = rs1;
    iq.in_rs2    = rs2;
    iq.out_ready = ordy;
    #1;
    chk("in_ready", {31'h0, iq.in_ready}, {31'h0, exp_cnt < 4});
    chk("out_valid", {31'h0, iq.out_valid}, {31'h0, exp_cnt != 0});
    chk("vl_pre_edge", vl, vl_exp);
    chk("vill_pre_edge", {31'h0, vill}, {31'h0, vill_exp});
    if (exp_cnt == 0) chk("out_instr_empty", iq.out_instr, 32'h0);
    if (flush) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      logic do_push, do_pop;
      do_push = v && (exp_cnt < 4);
      do_pop  = ordy && (exp_cnt != 0);
      if (do_pop) begin
        if (sb.size() == 0) chk("pop_scoreboard_empty", 32'(sb.size()), 32'd1);
        else chk("pop_order", iq.out_instr, sb.pop_front());
        exp_cnt--;
      end
      if (do_push) begin
        sb.push_back(ins);
        exp_cnt++;
      end
    end
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(exp_cnt));
  endtask

  task automatic vset(input string tag, input logic [31:0] ins, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] new_vl, input logic new_vill);
    step(1'b1, ins, rs1, rs2, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    vl_exp   = new_vl;
    vill_exp = new_vill;
    chk({tag, "_vl"}, vl, vl_exp);
    chk({tag, "_vill"}, {31'h0, vill}, {31'h0, vill_exp});
  endtask

  initial begin
    iq.in_valid  = 1'b0;
    iq.in_instr  = 32'h0;
    iq.in_rs1    = 32'h0;
    iq.in_rs2    = 32'h0;
    iq.out_ready = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_out_valid", {31'h0, iq.out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, iq.in_ready}, 32'h1);
    chk("rst_vl", vl, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill to DEPTH with the decoder stalled; the fifth word must be held off.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h1000_0013 | (i << 12), 32'h0, 32'h0, 1'b0);
    chk("full_in_ready", {31'h0, iq.in_ready}, 32'h0);
    chk("full_count", 32'(count), 32'd4);
    // A pop while full must not admit a same-cycle push.
    step(1'b1, 32'hBAD0_0013, 32'h0, 32'h0, 1'b1);
    chk("full_pop_no_push", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("drained_count", 32'(count), 32'h0);

    vset("vsetvli_e32m1_100", f_vsetvli(8'h10, 5'd5, 5'd1), 32'd100, 32'h0, 32'd16, 1'b0);
    vset("vsetvli_e32m1_10", f_vsetvli(8'h10, 5'd5, 5'd1), 32'd10, 32'h0, 32'd10, 1'b0);
    vset("vsetivli_5_e8m8", f_vsetivli(8'h03, 5'd5), 32'hFFFF, 32'h0, 32'd5, 1'b0);
    vset("vsetvli_x0_rd1", f_vsetvli(8'h1F, 5'd0, 5'd1), 32'd7, 32'h0, 32'd4, 1'b0);
    vset("vsetvli_x0_x0", f_vsetvli(8'h10, 5'd0, 5'd0), 32'd7, 32'h0, 32'd4, 1'b0);
    vset("vlmul_100", f_vsetvli(8'h04, 5'd5, 5'd1), 32'd10, 32'h0, 32'd0, 1'b1);
    vset("vsetvl_rs2_100", f_vsetvl(5'd5), 32'd3, 32'h100, 32'd0, 1'b1);
    vset("vsetvl_rs2_08", f_vsetvl(5'd5), 32'd3, 32'h08, 32'd3, 1'b0);

    // Concurrent push/pop at occupancy 2; pointers wrap several times.
    step(1'b1, 32'h2000_0013, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h2000_1013, 32'h0, 32'h0, 1'b0);
    for (int i = 2; i < 8; i++) begin
      step(1'b1, 32'h2000_0013 | (i << 12), 32'h0, 32'h0, 1'b1);
      chk("concurrent_count", 32'(count), 32'd2);
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Flush drops queued entries and the word offered alongside it; vl is kept.
    step(1'b1, 32'h3000_0013, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h3000_1013, 32'h0, 32'h0, 1'b0);
    flush = 1'b1;
    step(1'b1, 32'h3000_F013, 32'h0, 32'h0, 1'b1);
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_vl", vl, 32'd3);
    step(1'b1, 32'h3000_2013, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Asynchronous reset in the middle of traffic.
    step(1'b1, 32'h4000_0013, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h4000_1013, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    iq.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_cnt  = 0;
    vl_exp   = 32'h0;
    vill_exp = 1'b0;
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_out_valid", {31'h0, iq.out_valid}, 32'h0);
    chk("midrst_out_instr", iq.out_instr, 32'h0);
    chk("midrst_vl", vl, 32'h0);
    chk("midrst_vill", {31'h0, vill}, 32'h0);
    chk("midrst_in_ready", {31'h0, iq.in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h5000_0013, 32'h0, 32'h0, 1'b0);
    chk("post_rst_first_push", iq.out_instr, 32'h5000_0013);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("final_count", 32'(count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
